fifo_wr_arbiter: RTL and testbench

Round-robin write arbiter that shares one synchronous FIFO write port between `N_REQ` producers. Each producer offers bytes on a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to `BURST_LEN` beats and steers its data onto the FIFO `din`/`wr_en` pins, honouring `full`. It sits directly in front of the team's `fifo_generator_0`-based sync FIFO, in the same clock domain.

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 36 +++
 rtl/fifo_wr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and default sizing for the FIFO write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int C_N_REQ_DEF     = 4;
    localparam int C_DATA_W_DEF    = 8;
    localparam int C_BURST_LEN_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker; first valid after last_idx.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = C_N_REQ_DEF
) (
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [$clog2(N_REQ)-1:0] last_idx,
    output logic                     any,
    output logic [$clog2(N_REQ)-1:0] idx
);

    localparam int c_IDX_W = $clog2(N_REQ);

    logic [c_IDX_W-1:0] w_cand;

    // Walk offsets from farthest to nearest so the nearest valid wins.
    always_comb begin
        any    = |req_valid;
        idx    = '0;
        w_cand = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            w_cand = c_IDX_W'((int'(last_idx) + i) % N_REQ);
            if (req_valid[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_wr_arbiter
// Description : Round-robin burst arbiter sharing one FIFO write port.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = C_N_REQ_DEF,
    parameter int DATA_W    = C_DATA_W_DEF,
    parameter int BURST_LEN = C_BURST_LEN_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         fifo_din,
    output logic                      fifo_wr_en,
    input  logic                      fifo_full,
    output logic [$clog2(N_REQ)-1:0]  grant_idx,
    output logic                      busy
);

    localparam int c_IDX_W = $clog2(N_REQ);
    localparam int c_CNT_W = $clog2(BURST_LEN);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(BURST_LEN - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_INIT = c_IDX_W'(N_REQ - 1);

    arb_state_t         r_state, w_state_nxt;
    logic [c_IDX_W-1:0] r_grant_idx, w_grant_nxt;
    logic [c_IDX_W-1:0] r_last_idx, w_last_nxt;
    logic [c_CNT_W-1:0] r_beat_cnt, w_cnt_nxt;

    logic               w_any;
    logic [c_IDX_W-1:0] w_pick_idx;
    logic               w_valid_g;
    logic               w_beat;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req_valid (req_valid),
        .last_idx  (r_last_idx),
        .any       (w_any),
        .idx       (w_pick_idx)
    );

    assign w_valid_g = req_valid[r_grant_idx];
    assign w_beat    = (r_state == BURST) && w_valid_g && !fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
            r_last_idx  <= c_LAST_INIT;
            r_beat_cnt  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_nxt;
            r_last_idx  <= w_last_nxt;
            r_beat_cnt  <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_idx;
        w_last_nxt  = r_last_idx;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                end
            end
            BURST: begin
                // Early release: producer went quiet, hand the port back.
                if (!w_valid_g) begin
                    w_state_nxt = IDLE;
                    w_last_nxt  = r_grant_idx;
                end else if (w_beat) begin
                    if (r_beat_cnt == c_LAST_BEAT) begin
                        w_state_nxt = IDLE;
                        w_last_nxt  = r_grant_idx;
                    end else begin
                        w_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        fifo_din   = '0;
        fifo_wr_en = 1'b0;
        busy       = (r_state == BURST);
        grant_idx  = r_grant_idx;
        if (r_state == BURST) begin
            req_ready[r_grant_idx] = !fifo_full;
            fifo_din               = req_data[int'(r_grant_idx) * DATA_W +: DATA_W];
            fifo_wr_en             = w_beat;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_wr_arbiter
// Description : Randomized self-checking bench against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BL = 4;
    localparam int IW = $clog2(N);

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   fifo_din;
    logic            fifo_wr_en;
    logic            fifo_full;
    logic [IW-1:0]   grant_idx;
    logic            busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level model: who owns the port, how many beats it has had.
    int owner;
    int beats;
    int last_owner;
    int seq [N];
    logic [N-1:0] accepted;
    logic [N-1:0] exp_ready;
    int mode;
    int full_run;

    fifo_wr_arbiter #(
        .N_REQ     (N),
        .DATA_W    (DW),
        .BURST_LEN (BL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .grant_idx  (grant_idx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [DW-1:0] byte_of(input int p, input int s);
        return DW'((p << 6) | ((s + 16) & 63));
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (!(req_valid[i] && !accepted[i])) begin
                case (mode)
                    0:       req_valid[i] = (i == 0);
                    1:       req_valid[i] = 1'b1;
                    4:       req_valid[i] = (i == 1);
                    default: req_valid[i] = ($urandom_range(0, 3) != 0);
                endcase
            end
            req_data[i*DW +: DW] = byte_of(i, seq[i]);
        end
        case (mode)
            2: fifo_full = ($urandom_range(0, 3) == 0);
            3: begin
                if (full_run > 0) begin
                    fifo_full = 1'b1;
                    full_run--;
                end else if ($urandom_range(0, 9) == 0) begin
                    fifo_full = 1'b1;
                    full_run  = 4;
                end else begin
                    fifo_full = 1'b0;
                end
            end
            default: fifo_full = 1'b0;
        endcase
    endtask

    task automatic compare_outputs();
        logic [N-1:0]  er;
        logic          ew;
        logic [DW-1:0] ed;
        er = '0;
        ew = 1'b0;
        ed = '0;
        if (owner >= 0) begin
            er[owner] = !fifo_full;
            ew = req_valid[owner] && !fifo_full;
            ed = byte_of(owner, seq[owner]);
            chk("grant_idx", 32'(grant_idx), 32'(owner));
        end
        exp_ready = er;
        chk("busy", 32'(busy), 32'(owner >= 0));
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("fifo_wr_en", 32'(fifo_wr_en), 32'(ew));
        chk("fifo_din", 32'(fifo_din), 32'(ed));
    endtask

    task automatic model_edge();
        bit found;
        for (int i = 0; i < N; i++) begin
            accepted[i] = req_valid[i] && exp_ready[i];
            if (accepted[i]) seq[i]++;
        end
        if (owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= N; k++) begin
                if (!found && req_valid[(last_owner + k) % N]) begin
                    owner = (last_owner + k) % N;
                    beats = 0;
                    found = 1'b1;
                end
            end
        end else if (!req_valid[owner]) begin
            last_owner = owner;
            owner      = -1;
        end else if (!fifo_full) begin
            beats++;
            if (beats == BL) begin
                last_owner = owner;
                owner      = -1;
            end
        end
    endtask

    task automatic run(input int m, input int cycles);
        mode = m;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            drive_inputs();
            #1 compare_outputs();
            @(posedge clk);
            model_edge();
        end
    endtask

    // Called at a negedge with inputs already driven; asserts reset mid-cycle.
    task automatic apply_reset();
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_fifo_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_fifo_din", 32'(fifo_din), 32'd0);
        chk("rst_grant_idx", 32'(grant_idx), 32'd0);
        owner      = -1;
        beats      = 0;
        last_owner = N - 1;
        accepted   = '0;
        exp_ready  = '0;
        req_valid  = '0;
        fifo_full  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit hit;
        rst        = 1'b1;
        req_valid  = '0;
        req_data   = '0;
        fifo_full  = 1'b0;
        accepted   = '0;
        exp_ready  = '0;
        full_run   = 0;
        mode       = 0;
        owner      = -1;
        beats      = 0;
        last_owner = N - 1;
        for (int i = 0; i < N; i++) seq[i] = 0;

        @(negedge clk);
        apply_reset();

        run(0, 20);
        run(1, 45);
        run(2, 300);
        run(3, 300);

        // Reset during the second beat of producer 1's burst.
        mode = 1;
        hit  = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(negedge clk);
            drive_inputs();
            #1 compare_outputs();
            if (owner == 1 && beats == 1) begin
                chk("pre_rst_wr_en", 32'(fifo_wr_en), 32'd1);
                hit = 1'b1;
            end else begin
                @(posedge clk);
                model_edge();
            end
        end
        chk("reach_mid_burst", 32'(hit), 32'd1);
        if (hit) apply_reset();
        run(1, 2);
        chk("first_grant_after_rst", 32'(grant_idx), 32'd0);
        run(1, 20);

        // Fresh reset leaves last_idx at N-1, so producer 1 is found by wrapping past 0.
        @(negedge clk);
        apply_reset();
        run(4, 2);
        chk("wrap_grant", 32'(grant_idx), 32'd1);
        run(4, 12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
